mastermind_game_tracker: RTL and testbench

//  Downstream of the datapath/compare stage. Consumes the per-guess red/white feedback

---
 rtl/mastermind_pkg.sv | 16 +
 rtl/mastermind_history_ram.sv | 51 +++++
 rtl/mastermind_game_tracker.sv | 143 ++++++++++++++
 tb/tb_mastermind_game_tracker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// rtl/mastermind_pkg.sv - shared game-state encoding and default sizing for the mastermind tracker
package mastermind_pkg;

  // Game outcome as seen by the controller and the result displays.
  typedef enum logic [1:0] {
    PLAYING = 2'd0,
    WON     = 2'd1,
    LOST    = 2'd2
  } game_state_t;

  // Default sizing: a 4-peg code, 8 guesses per game, 3-bit peg counts.
  localparam int DEF_PEGS        = 4;
  localparam int DEF_MAX_GUESSES = 8;
  localparam int DEF_CNT_W       = 3;

endpackage

// File: rtl/mastermind_history_ram.sv
// rtl/mastermind_history_ram.sv - per-game red/white feedback register file, one write port, one async read port
module mastermind_history_ram
  import mastermind_pkg::*;
#(
  parameter int DEPTH   = DEF_MAX_GUESSES,
  parameter int ENTRY_W = 2 * DEF_CNT_W,
  parameter int ADDR_W  = $clog2(DEF_MAX_GUESSES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Storage: cleared by reset or a new game, otherwise written one entry per accepted guess.
  // The address is matched per entry so an out-of-range address simply hits nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i)) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  // Read port: combinational; addresses beyond the table read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/mastermind_game_tracker.sv
// rtl/mastermind_game_tracker.sv - counts guesses, keeps feedback history and decides win/loss
module mastermind_game_tracker
  import mastermind_pkg::*;
#(
  parameter  int MAX_GUESSES = DEF_MAX_GUESSES,
  parameter  int PEGS        = DEF_PEGS,
  parameter  int CNT_W       = DEF_CNT_W,
  localparam int GU_W        = $clog2(MAX_GUESSES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
  input  logic             result_valid,
  input  logic [CNT_W-1:0] red,
  input  logic [CNT_W-1:0] white,
  input  logic [GU_W-1:0]  hist_idx,
  output logic [CNT_W-1:0] hist_red,
  output logic [CNT_W-1:0] hist_white,
  output logic             hist_valid,
  output logic [CNT_W-1:0] last_red,
  output logic [CNT_W-1:0] last_white,
  output logic [GU_W-1:0]  guesses_used,
  output logic [1:0]       game_state,
  output logic             accept_guess,
  output logic             protocol_err
);

  // Peg limit and guess limit expressed at the widths they are compared against.
  localparam logic [CNT_W:0]  PEGS_W = (CNT_W + 1)'(PEGS);
  localparam logic [GU_W-1:0] MAX_W  = GU_W'(MAX_GUESSES);

  game_state_t state_q;
  game_state_t state_d;

  logic [GU_W-1:0]    used_q;
  logic [GU_W-1:0]    used_inc;
  logic [CNT_W-1:0]   last_red_q;
  logic [CNT_W-1:0]   last_white_q;
  logic               perr_q;

  logic [CNT_W:0]     fb_sum;
  logic               fb_legal;
  logic               fb_win;
  logic               strobe_live;
  logic               take_guess;
  logic               bad_guess;
  logic [2*CNT_W-1:0] rd_entry;

  // Feedback legality: the sum is one bit wider so 7+7 cannot wrap into a legal value.
  assign fb_sum   = {1'b0, red} + {1'b0, white};
  assign fb_legal = ({1'b0, red} <= PEGS_W) && (fb_sum <= PEGS_W);
  assign fb_win   = ({1'b0, red} == PEGS_W);

  // A strobe only matters while playing and when no new game is being requested;
  // in WON/LOST it is dropped without raising an error.
  assign strobe_live = result_valid && (state_q == PLAYING) && !new_game;
  assign take_guess  = strobe_live && fb_legal;
  assign bad_guess   = strobe_live && !fb_legal;
  assign used_inc    = used_q + GU_W'(1);

  // Game FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PLAYING;
    end else begin
      state_q <= state_d;
    end
  end

  // Game FSM next state: a win on the last guess beats running out of guesses.
  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = PLAYING;
    end else begin
      case (state_q)
        PLAYING: begin
          if (take_guess) begin
            if (fb_win) begin
              state_d = WON;
            end else if (used_inc == MAX_W) begin
              state_d = LOST;
            end
          end
        end
        WON, LOST: state_d = state_q;
        default:   state_d = PLAYING;
      endcase
    end
  end

  // Guess counter, most-recent feedback and sticky protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      used_q       <= '0;
      last_red_q   <= '0;
      last_white_q <= '0;
      perr_q       <= 1'b0;
    end else if (new_game) begin
      used_q       <= '0;
      last_red_q   <= '0;
      last_white_q <= '0;
      perr_q       <= 1'b0;
    end else begin
      if (take_guess) begin
        used_q       <= used_inc;
        last_red_q   <= red;
        last_white_q <= white;
      end
      if (bad_guess) begin
        perr_q <= 1'b1;
      end
    end
  end

  mastermind_history_ram #(
    .DEPTH   (MAX_GUESSES),
    .ENTRY_W (2 * CNT_W),
    .ADDR_W  (GU_W)
  ) u_history (
    .clk   (clk),
    .reset (reset),
    .clr   (new_game),
    .we    (take_guess),
    .waddr (used_q),
    .wdata ({red, white}),
    .raddr (hist_idx),
    .rdata (rd_entry)
  );

  // History read-out is masked to zero for guesses not yet taken this game.
  assign hist_valid   = (hist_idx < used_q);
  assign hist_red     = hist_valid ? rd_entry[2*CNT_W-1:CNT_W] : '0;
  assign hist_white   = hist_valid ? rd_entry[CNT_W-1:0]       : '0;

  assign last_red     = last_red_q;
  assign last_white   = last_white_q;
  assign guesses_used = used_q;
  assign game_state   = state_q;
  assign accept_guess = (state_q == PLAYING);
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_mastermind_game_tracker.sv
// tb/tb_mastermind_game_tracker.sv - randomized self-checking bench for mastermind_game_tracker
module tb_mastermind_game_tracker;

  localparam int MAXG  = 8;
  localparam int PEGS  = 4;
  localparam int CNT_W = 3;
  localparam int GU_W  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             new_game;
  logic             result_valid;
  logic [CNT_W-1:0] red;
  logic [CNT_W-1:0] white;
  logic [GU_W-1:0]  hist_idx;
  logic [CNT_W-1:0] hist_red;
  logic [CNT_W-1:0] hist_white;
  logic             hist_valid;
  logic [CNT_W-1:0] last_red;
  logic [CNT_W-1:0] last_white;
  logic [GU_W-1:0]  guesses_used;
  logic [1:0]       game_state;
  logic             accept_guess;
  logic             protocol_err;

  mastermind_game_tracker dut (
    .clk          (clk),
    .reset        (reset),
    .new_game     (new_game),
    .result_valid (result_valid),
    .red          (red),
    .white        (white),
    .hist_idx     (hist_idx),
    .hist_red     (hist_red),
    .hist_white   (hist_white),
    .hist_valid   (hist_valid),
    .last_red     (last_red),
    .last_white   (last_white),
    .guesses_used (guesses_used),
    .game_state   (game_state),
    .accept_guess (accept_guess),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a list of accepted (red, white) pairs plus game outcome.
  int m_red[$];
  int m_white[$];
  int m_state;   // 0 playing, 1 won, 2 lost
  int m_perr;
  int m_lred;
  int m_lwhite;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_red.delete();
    m_white.delete();
    m_state  = 0;
    m_perr   = 0;
    m_lred   = 0;
    m_lwhite = 0;
  endtask

  task automatic model_step(input bit ng, input bit rv, input int r, input int w);
    if (ng) begin
      model_reset();
    end else if (rv && m_state == 0) begin
      if (r > PEGS || r + w > PEGS) begin
        m_perr = 1;
      end else begin
        m_red.push_back(r);
        m_white.push_back(w);
        m_lred   = r;
        m_lwhite = w;
        if (r == PEGS)              m_state = 1;
        else if (m_red.size() == MAXG) m_state = 2;
      end
    end
  endtask

  task automatic check_hist(input string tag, input int idx);
    int vld;
    hist_idx = idx[GU_W-1:0];
    #1;
    vld = (idx < m_red.size()) ? 1 : 0;
    check({tag, ".hist_valid"}, hist_valid, vld);
    check({tag, ".hist_red"},   hist_red,   vld ? m_red[idx]   : 0);
    check({tag, ".hist_white"}, hist_white, vld ? m_white[idx] : 0);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},  game_state,   m_state);
    check({tag, ".used"},   guesses_used, m_red.size());
    check({tag, ".lred"},   last_red,     m_lred);
    check({tag, ".lwhite"}, last_white,   m_lwhite);
    check({tag, ".perr"},   protocol_err, m_perr);
    check({tag, ".accept"}, accept_guess, (m_state == 0) ? 1 : 0);
    check_hist(tag, $urandom_range(0, 15));
  endtask

  // One clock: drive, take the edge, advance the model, then sample after the edge.
  task automatic cycle(input string tag, input bit ng, input bit rv, input int r, input int w);
    new_game     = ng;
    result_valid = rv;
    red          = r[CNT_W-1:0];
    white        = w[CNT_W-1:0];
    @(posedge clk);
    model_step(ng, rv, r, w);
    #1;
    new_game     = 1'b0;
    result_valid = 1'b0;
    check_all(tag);
  endtask

  initial begin
    reset        = 1'b1;
    new_game     = 1'b0;
    result_valid = 1'b0;
    red          = '0;
    white        = '0;
    hist_idx     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset");
    for (int i = 0; i < 16; i++) check_hist("reset_hist", i);

    // 1: first guess lands in history slot 0
    cycle("t1", 0, 1, 1, 2);
    check("t1.used_const", guesses_used, 1);
    check_hist("t1_h0", 0);

    // 2: win on guess 3, further strobes ignored
    cycle("t2_ng", 1, 0, 0, 0);
    cycle("t2_g1", 0, 1, 0, 1);
    cycle("t2_g2", 0, 1, 2, 0);
    cycle("t2_g3", 0, 1, 4, 0);
    check("t2.won", game_state, 1);
    cycle("t2_ign", 0, 1, 1, 1);
    check("t2.used3", guesses_used, 3);

    // 3: eight misses lose; variant wins on the eighth
    cycle("t3_ng", 1, 0, 0, 0);
    for (int i = 0; i < MAXG; i++) cycle("t3_g", 0, 1, i % 4, (i + 1) % 2);
    check("t3.lost", game_state, 2);
    check("t3.used8", guesses_used, 8);
    for (int i = 0; i < MAXG; i++) check_hist("t3_h", i);
    cycle("t3v_ng", 1, 0, 0, 0);
    for (int i = 0; i < MAXG - 1; i++) cycle("t3v_g", 0, 1, 3, 1);
    cycle("t3v_last", 0, 1, 4, 0);
    check("t3v.won", game_state, 1);

    // 4: illegal feedback is flagged and not recorded
    cycle("t4_ng", 1, 0, 0, 0);
    cycle("t4_bad", 0, 1, 3, 2);
    check("t4.perr", protocol_err, 1);
    check_hist("t4_h0", 0);
    cycle("t4_wrap", 0, 1, 7, 7);
    cycle("t4_red5", 0, 1, 5, 0);

    // 5: new_game beats a same-cycle strobe
    cycle("t5_g", 0, 1, 2, 2);
    cycle("t5_both", 1, 1, 1, 1);
    check("t5.used0", guesses_used, 0);

    // 6: asynchronous reset mid-game
    for (int i = 0; i < 5; i++) cycle("t6_g", 0, 1, 1, 1);
    check("t6.used5", guesses_used, 5);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("t6_async");
    #1;
    reset = 1'b0;

    // Randomized play
    for (int n = 0; n < 1500; n++) begin
      bit ng;
      bit rv;
      int kind;
      int r;
      int w;
      ng   = (m_state != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      rv   = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        r = $urandom_range(0, 7);
        w = $urandom_range(0, 7);
      end else if (kind == 1) begin
        r = 4;
        w = 0;
      end else begin
        r = $urandom_range(0, 3);
        w = $urandom_range(0, 4 - r);
      end
      cycle("rnd", ng, rv, r, w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
